// File: rtl/qoi_stream_framer_if.sv
// qoi_stream_framer_if: chunk input and byte-stream output of the QOI framer.
// slave is the framer side, master is the producer/sink side.
interface qoi_stream_framer_if;
    logic [39:0] in_data;
    logic [2:0]  in_count;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport slave (
        input  in_data, in_count, in_last, out_ready,
        output in_ready, out_byte, out_valid, out_last
    );

    modport master (
        output in_data, in_count, in_last, out_ready,
        input  in_ready, out_byte, out_valid, out_last
    );
endinterface

// File: rtl/qoi_stream_framer.sv
// qoi_stream_framer: packs 0..5-byte chunks from qoi_core into a byte FIFO and
// emits one QOI file as a valid/ready byte stream.
// Macro QOI_FRAMER_HEADER_EN: when defined, the stream carries the 14-byte
// header and 8-byte end marker; when undefined, only raw body bytes are sent.
module qoi_stream_framer #(
    parameter int WIDTH      = 40,
    parameter int HEIGHT     = 30,
    parameter int CHANNELS   = 4,
    parameter int COLORSPACE = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    qoi_stream_framer_if.slave      bus,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overflow,
    output logic [15:0]             byte_total
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0] WIDTH_W  = 32'(WIDTH);
    localparam logic [31:0] HEIGHT_W = 32'(HEIGHT);
    localparam logic [7:0]  CHAN_B   = 8'(CHANNELS);
    localparam logic [7:0]  CSPACE_B = 8'(COLORSPACE);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BODY, S_TRAILER} state_t;

    state_t         state_reg, state_next;
    logic [3:0]     idx_reg, idx_next;
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]    occ_reg;
    logic           end_reg, overflow_reg, frame_done_reg;
    logic [15:0]    byte_total_reg;

    logic           out_valid_c, out_last_c, rd_en, xfer;
    logic [7:0]     out_byte_c;
    logic           in_phase, take_in, fits, wr_en, drop;
    logic [2:0]     cnt_c;
    logic [AW:0]    free_c;
    logic [7:0]     lane_byte [5];
    logic [AW-1:0]  lane_addr [5];

    function automatic logic [7:0] header_byte(input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'h71;
            4'd1:    b = 8'h6F;
            4'd2:    b = 8'h69;
            4'd3:    b = 8'h66;
            4'd4:    b = WIDTH_W[31:24];
            4'd5:    b = WIDTH_W[23:16];
            4'd6:    b = WIDTH_W[15:8];
            4'd7:    b = WIDTH_W[7:0];
            4'd8:    b = HEIGHT_W[31:24];
            4'd9:    b = HEIGHT_W[23:16];
            4'd10:   b = HEIGHT_W[15:8];
            4'd11:   b = HEIGHT_W[7:0];
            4'd12:   b = CHAN_B;
            4'd13:   b = CSPACE_B;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Input acceptance: free space uses the registered occupancy only.
    assign free_c   = DEPTH_C - occ_reg;
    assign cnt_c    = (bus.in_count > 3'd5) ? 3'd5 : bus.in_count;
    assign in_phase = (state_reg == S_HEADER) || (state_reg == S_BODY);
    assign take_in  = in_phase && !end_reg;
    assign fits     = (AW+1)'(cnt_c) <= free_c;
    assign wr_en    = take_in && fits && (cnt_c != 3'd0);
    assign drop     = take_in && !fits;
    assign xfer     = out_valid_c && bus.out_ready;

    // Byte lanes of a chunk, MSB byte first, mapped onto consecutive FIFO slots.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_lane
            assign lane_byte[gi] = bus.in_data[39-8*gi -: 8];
            assign lane_addr[gi] = wr_ptr_reg + AW'(gi);
        end
    endgenerate

    // Next-state and stream output decode.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        out_valid_c = 1'b0;
        out_byte_c  = 8'h00;
        out_last_c  = 1'b0;
        rd_en       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
`ifdef QOI_FRAMER_HEADER_EN
                    state_next = S_HEADER;
`else
                    state_next = S_BODY;
`endif
                    idx_next = 4'd0;
                end
            end
            S_HEADER: begin
                out_valid_c = 1'b1;
                out_byte_c  = header_byte(idx_reg);
                if (bus.out_ready) begin
                    idx_next = idx_reg + 4'd1;
                    if (idx_reg == 4'd13) begin
                        state_next = S_BODY;
                        idx_next   = 4'd0;
                    end
                end
            end
            S_BODY: begin
                out_valid_c = (occ_reg != '0);
                out_byte_c  = (occ_reg != '0) ? fifo_mem[rd_ptr_reg] : 8'h00;
                rd_en       = out_valid_c && bus.out_ready;
`ifdef QOI_FRAMER_HEADER_EN
                if (end_reg && (occ_reg == '0)) begin
                    state_next = S_TRAILER;
                    idx_next   = 4'd0;
                end
`else
                // Without a trailer the final body byte itself closes the frame.
                out_last_c = end_reg && (occ_reg == (AW+1)'(1));
                if (end_reg && ((occ_reg == '0) ||
                                ((occ_reg == (AW+1)'(1)) && bus.out_ready)))
                    state_next = S_IDLE;
`endif
            end
            S_TRAILER: begin
                out_valid_c = 1'b1;
                out_byte_c  = (idx_reg == 4'd7) ? 8'h01 : 8'h00;
                out_last_c  = (idx_reg == 4'd7);
                if (bus.out_ready) begin
                    idx_next = idx_reg + 4'd1;
                    if (idx_reg == 4'd7)
                        state_next = S_IDLE;
                end
            end
        endcase
    end

    // Control state, FIFO pointers, occupancy and status registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            idx_reg        <= 4'd0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            occ_reg        <= '0;
            end_reg        <= 1'b0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            byte_total_reg <= 16'd0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            frame_done_reg <= (state_reg != S_IDLE) && (state_next == S_IDLE);
            if (state_reg == S_IDLE) begin
                if (start) begin
                    byte_total_reg <= 16'd0;
                    overflow_reg   <= 1'b0;
                    end_reg        <= 1'b0;
                    wr_ptr_reg     <= '0;
                    rd_ptr_reg     <= '0;
                    occ_reg        <= '0;
                end
            end else begin
                if (xfer && (byte_total_reg != 16'hFFFF))
                    byte_total_reg <= byte_total_reg + 16'd1;
                if (wr_en)
                    wr_ptr_reg <= wr_ptr_reg + AW'(cnt_c);
                if (rd_en)
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                occ_reg <= occ_reg + (AW+1)'(wr_en ? cnt_c : 3'd0) - (AW+1)'(rd_en);
                if (drop)
                    overflow_reg <= 1'b1;
                if (take_in && bus.in_last)
                    end_reg <= 1'b1;
            end
        end
    end

    // FIFO storage: up to five bytes land per cycle starting at the write pointer.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (wr_en && (3'(k) < cnt_c))
                fifo_mem[lane_addr[k]] <= lane_byte[k];
        end
    end

    assign bus.out_valid = out_valid_c;
    assign bus.out_byte  = out_byte_c;
    assign bus.out_last  = out_last_c;
    assign bus.in_ready  = in_phase && (free_c >= (AW+1)'(5));
    assign busy          = (state_reg != S_IDLE);
    assign frame_done    = frame_done_reg;
    assign overflow      = overflow_reg;
    assign byte_total    = byte_total_reg;
endmodule
